// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing definitions: default 640x480@60 geometry, counter
// types sized for the totals, and a window helper used by the axis counters.
package vga_timing_gen_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    localparam int HCOUNT_WIDTH = 10;
    localparam int VCOUNT_WIDTH = 10;

    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    localparam int H_TOTAL = SCREEN_WIDTH + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = SCREEN_HEIGHT + V_FP + V_SYNC + V_BP;

    typedef logic [HCOUNT_WIDTH-1:0] hcount_t;
    typedef logic [VCOUNT_WIDTH-1:0] vcount_t;
    typedef logic [15:0]             frame_cnt_t;

    // True when lo <= value < hi; used for the sync window of each axis.
    function automatic logic inWindow(input int value, input int lo, input int hi);
        return (value >= lo) && (value < hi);
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing bundle: the generator drives it through src, renderers read it
// through dst.
interface vga_if;

    vga_timing_gen_pkg::hcount_t hcount;
    vga_timing_gen_pkg::vcount_t vcount;
    logic                        hsync;
    logic                        vsync;
    logic                        blank;

    modport src (output hcount, output vcount, output hsync, output vsync, output blank);
    modport dst (input  hcount, input  vcount, input  hsync, input  vsync, input  blank);

endinterface

// File: rtl/vga_axis_counter.sv
// One axis of the VGA raster (horizontal or vertical). The count wraps at
// ACTIVE+FP+SYNC+BP-1; blank and sync are derived from the next count and
// registered on the same edge, so they line up with count_out.
// wrap_out is combinational: it flags that this step is the terminal one,
// so the caller can chain the next axis and register its own pulses.
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int WIDTH  = 10
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             step_in,
    output logic [WIDTH-1:0] count_out,
    output logic             blank_out,
    output logic             sync_out,
    output logic             wrap_out
);
    import vga_timing_gen_pkg::*;

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

    if (TOTAL > (1 << WIDTH)) begin : gTotalTooWide
        $error("vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, WIDTH);
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             blank_q, blank_d;
    logic             sync_q, sync_d;

    // Next count plus the blank/sync levels that describe that next position.
    always_comb begin
        wrap_out = step_in && (count_q == LAST);
        count_d  = count_q;
        if (step_in) begin
            count_d = wrap_out ? '0 : count_q + 1'b1;
        end
        blank_d = (32'(count_d) >= ACTIVE);
        sync_d  = inWindow(32'(count_d), ACTIVE + FP, ACTIVE + FP + SYNC) ? POL : ~POL;
    end

    // Axis state register; reset lands on the first visible position.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            count_q <= '0;
            blank_q <= 1'b0;
            sync_q  <= ~POL;
        end else begin
            count_q <= count_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
        end
    end

    assign count_out = count_q;
    assign blank_out = blank_q;
    assign sync_out  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source. Two chained axis counters advanced by a pixel
// enable drive the vga_if src modport, plus registered line/frame pulses.
// Optional feature macro: VGA_FRAME_CNT_EN adds a 16-bit frame counter port.
module vga_timing_gen #(
    parameter int H_ACTIVE  = vga_timing_gen_pkg::SCREEN_WIDTH,
    parameter int H_FP      = vga_timing_gen_pkg::H_FP,
    parameter int H_SYNC    = vga_timing_gen_pkg::H_SYNC,
    parameter int H_BP      = vga_timing_gen_pkg::H_BP,
    parameter int V_ACTIVE  = vga_timing_gen_pkg::SCREEN_HEIGHT,
    parameter int V_FP      = vga_timing_gen_pkg::V_FP,
    parameter int V_SYNC    = vga_timing_gen_pkg::V_SYNC,
    parameter int V_BP      = vga_timing_gen_pkg::V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            pix_en_in,
    vga_if.src                              vga,
    output logic                            line_start_out,
`ifdef VGA_FRAME_CNT_EN
    output logic                            frame_start_out,
    output vga_timing_gen_pkg::frame_cnt_t  frame_cnt_out
`else
    output logic                            frame_start_out
`endif
);
    import vga_timing_gen_pkg::*;

    hcount_t hCount;
    vcount_t vCount;
    logic    hBlank, vBlank;
    logic    hSync, vSync;
    logic    hWrap, vWrap;
    logic    vStep;
    logic    lineStart_q, frameStart_q;

    assign vStep = pix_en_in && hWrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HSYNC_POL),
        .WIDTH  (HCOUNT_WIDTH)
    ) uHorizontal (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .step_in   (pix_en_in),
        .count_out (hCount),
        .blank_out (hBlank),
        .sync_out  (hSync),
        .wrap_out  (hWrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VSYNC_POL),
        .WIDTH  (VCOUNT_WIDTH)
    ) uVertical (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .step_in   (vStep),
        .count_out (vCount),
        .blank_out (vBlank),
        .sync_out  (vSync),
        .wrap_out  (vWrap)
    );

    // Line/frame pulses registered on the edge where the counters wrap.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            lineStart_q  <= hWrap;
            frameStart_q <= hWrap && vWrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    frame_cnt_t frameCnt_q, frameCnt_d;

    // Frame counter steps on the same edge that raises frame_start_out.
    always_comb begin
        frameCnt_d = frameCnt_q;
        if (hWrap && vWrap) begin
            frameCnt_d = frameCnt_q + 1'b1;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            frameCnt_q <= '0;
        end else begin
            frameCnt_q <= frameCnt_d;
        end
    end

    assign frame_cnt_out = frameCnt_q;
`endif

    assign vga.hcount      = hCount;
    assign vga.vcount      = vCount;
    assign vga.hsync       = hSync;
    assign vga.vsync       = vSync;
    assign vga.blank       = hBlank || vBlank;
    assign line_start_out  = lineStart_q;
    assign frame_start_out = frameStart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen, run on a reduced raster (32x19 total) so whole
// frames fit in a short run. A reference model pushes the expected outputs
// for each cycle into a scoreboard queue; they are popped and compared
// after the edge. Directed tallies check pulse and sync widths.
module tb_vga_timing_gen;

    localparam int HA  = 16;
    localparam int HFP = 4;
    localparam int HS  = 6;
    localparam int HBP = 6;
    localparam int VA  = 12;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    logic clk;
    logic rstN;
    logic pixEn;
    logic lineStart;
    logic frameStart;
    logic [15:0] frameCnt;

    vga_if vgaBus ();

    vga_timing_gen #(
        .H_ACTIVE  (HA),
        .H_FP      (HFP),
        .H_SYNC    (HS),
        .H_BP      (HBP),
        .V_ACTIVE  (VA),
        .V_FP      (VFP),
        .V_SYNC    (VS),
        .V_BP      (VBP),
        .HSYNC_POL (1'b0),
        .VSYNC_POL (1'b0)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rstN),
        .pix_en_in       (pixEn),
        .vga             (vgaBus.src),
        .line_start_out  (lineStart),
`ifdef VGA_FRAME_CNT_EN
        .frame_start_out (frameStart),
        .frame_cnt_out   (frameCnt)
`else
        .frame_start_out (frameStart)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign frameCnt = 16'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   testCount = 0;
    int   failCount = 0;
    obs_t scoreboard[$];

    int mh = 0;
    int mv = 0;
    int mfc = 0;
    logic mLs = 1'b0;
    logic mFs = 1'b0;

    int hsLow = 0;
    int vsLow = 0;
    int blankHigh = 0;
    int linePulses = 0;
    int framePulses = 0;

    task automatic checkInt(input string tag, input int observed, input int expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        obs_t observed;
        obs_t expected;
        observed = '{h: vgaBus.hcount, v: vgaBus.vcount, hs: vgaBus.hsync, vs: vgaBus.vsync,
                     bl: vgaBus.blank, ls: lineStart, fs: frameStart, fc: frameCnt};
        if (scoreboard.size() == 0) begin
            checkInt({tag, "_queue_empty"}, 0, 1);
        end else begin
            expected = scoreboard.pop_front();
            testCount++;
            assert (observed === expected) else begin
                failCount++;
                $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            end
        end
        if (observed.hs === 1'b0) hsLow++;
        if (observed.vs === 1'b0) vsLow++;
        if (observed.bl === 1'b1) blankHigh++;
        if (observed.ls === 1'b1) linePulses++;
        if (observed.fs === 1'b1) framePulses++;
    endtask

    task automatic applyStimulus(input string tag, input logic rstIn, input logic enIn);
        obs_t expected;
        logic lineWrap;
        rstN  = rstIn;
        pixEn = enIn;
        if (!rstIn) begin
            mh = 0; mv = 0; mfc = 0; mLs = 1'b0; mFs = 1'b0;
        end else if (enIn) begin
            lineWrap = (mh == HT - 1);
            mLs = lineWrap;
            mFs = lineWrap && (mv == VT - 1);
            mh  = lineWrap ? 0 : mh + 1;
            if (lineWrap) mv = (mv == VT - 1) ? 0 : mv + 1;
`ifdef VGA_FRAME_CNT_EN
            if (mFs) mfc = (mfc + 1) % 65536;
`endif
        end else begin
            mLs = 1'b0;
            mFs = 1'b0;
        end
        expected.h  = 10'(mh);
        expected.v  = 10'(mv);
        expected.hs = !((mh >= HA + HFP) && (mh < HA + HFP + HS));
        expected.vs = !((mv >= VA + VFP) && (mv < VA + VFP + VS));
        expected.bl = (mh >= HA) || (mv >= VA);
        expected.ls = mLs;
        expected.fs = mFs;
        expected.fc = 16'(mfc);
        scoreboard.push_back(expected);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic clearTallies();
        hsLow = 0; vsLow = 0; blankHigh = 0; linePulses = 0; framePulses = 0;
    endtask

    initial begin
        rstN  = 1'b0;
        pixEn = 1'b1;

        // Reset held with enable high: outputs sit at reset values.
        for (int i = 0; i < 3; i++) applyStimulus("reset_hold", 1'b0, 1'b1);
        checkInt("reset_hcount", int'(vgaBus.hcount), 0);
        checkInt("reset_hsync", int'(vgaBus.hsync), 1);

        // One full line from release: single line pulse, blank and hsync widths.
        clearTallies();
        for (int i = 0; i < HT; i++) applyStimulus("line0", 1'b1, 1'b1);
        checkInt("line0_line_pulses", linePulses, 1);
        checkInt("line0_hsync_low", hsLow, HS);
        checkInt("line0_blank_high", blankHigh, HT - HA);
        checkInt("line0_vcount", int'(vgaBus.vcount), 1);

        // Remainder of the frame: vsync window, pulses at return to (0,0).
        clearTallies();
        for (int i = 0; i < HT * (VT - 1); i++) applyStimulus("frame0", 1'b1, 1'b1);
        checkInt("frame0_frame_pulses", framePulses, 1);
        checkInt("frame0_line_pulses", linePulses, VT - 1);
        checkInt("frame0_vsync_low", vsLow, VS * HT);
        checkInt("frame0_frame_start", int'(frameStart), 1);
        checkInt("frame0_line_start", int'(lineStart), 1);

        // Enable pattern 1,0,0,1: two advances, no pulses while disabled.
        clearTallies();
        applyStimulus("gate_1", 1'b1, 1'b1);
        applyStimulus("gate_0a", 1'b1, 1'b0);
        applyStimulus("gate_0b", 1'b1, 1'b0);
        applyStimulus("gate_1b", 1'b1, 1'b1);
        checkInt("gate_hcount", int'(vgaBus.hcount), 2);
        checkInt("gate_pulses", linePulses + framePulses, 0);

        // Run to a mid-frame position inside hsync, then reset.
        for (int i = 0; i < 2 * HT * VT && !(mh == HA + HFP && mv == 8); i++)
            applyStimulus("seek", 1'b1, 1'b1);
        checkInt("seek_reached", int'(vgaBus.hcount), HA + HFP);
        applyStimulus("mid_reset", 1'b0, 1'b1);
        checkInt("mid_reset_vcount", int'(vgaBus.vcount), 0);

        // Release: counting restarts at 0,1,2 and a normal frame follows.
        clearTallies();
        for (int i = 0; i < HT * VT; i++) applyStimulus("post_reset", 1'b1, 1'b1);
        checkInt("post_reset_frame_pulses", framePulses, 1);
        checkInt("post_reset_line_pulses", linePulses, VT);
        checkInt("post_reset_hsync_low", hsLow, HS * VT);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
